// File: rtl/reg_bank.sv
// Parametrised control/status register bank behind a simple strobe bus.
// Each bit is software RW, write-1-to-clear sticky, or hardware-owned, selected by the packed masks.
module reg_bank #(
    parameter int DataWidth  = 16,
    parameter int NumRegs    = 16,
    parameter int AddrWidth  = 5,
    parameter logic [NumRegs*DataWidth-1:0] ResetValue = '0,
    parameter logic [NumRegs*DataWidth-1:0] SwWrMask   = '0,
    parameter logic [NumRegs*DataWidth-1:0] W1cMask    = '0,
    parameter int IrqStatReg = 9,
    parameter int IrqEnReg   = 9
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic                           we_i,
    input  logic                           re_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           rvalid_o,
    output logic                           err_o,
    input  logic [NumRegs*DataWidth-1:0]   hw_data_i,
    input  logic [NumRegs-1:0]             hw_we_i,
    input  logic [NumRegs*DataWidth-1:0]   hw_set_i,
    output logic [NumRegs*DataWidth-1:0]   regs_o,
    output logic [NumRegs-1:0]             wr_pulse_o,
    output logic                           irq_o
);

    localparam logic [DataWidth-1:0] IrqMask = W1cMask[IrqStatReg*DataWidth +: DataWidth];

    logic [31:0]                   w_addr_ext;
    logic                          w_in_range;
    logic                          w_wr_valid;
    logic [NumRegs*DataWidth-1:0]  w_regs;
    logic [DataWidth-1:0]          w_rd_data;

    logic [DataWidth-1:0]          r_rdata;
    logic                          r_rvalid;
    logic                          r_err;
    logic [NumRegs-1:0]            r_wr_pulse;
    logic                          r_irq;

    assign w_addr_ext = {{(32-AddrWidth){1'b0}}, addr_i};
    assign w_in_range = (w_addr_ext < 32'(NumRegs));
    assign w_wr_valid = we_i && w_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < NumRegs; gi++) begin : g_reg
            localparam logic [DataWidth-1:0] RstVal = ResetValue[gi*DataWidth +: DataWidth];
            localparam logic [DataWidth-1:0] W1c    = W1cMask[gi*DataWidth +: DataWidth];
            // A bit present in both masks behaves as W1C, so RW excludes W1C bits.
            localparam logic [DataWidth-1:0] Rw     = SwWrMask[gi*DataWidth +: DataWidth] & ~W1c;
            localparam logic [DataWidth-1:0] Hw     = ~(Rw | W1c);

            logic                 w_sel;
            logic [DataWidth-1:0] w_val_next;
            logic [DataWidth-1:0] r_val;

            assign w_sel = w_wr_valid && (addr_i == AddrWidth'(gi));

            always_comb begin
                w_val_next = r_val;
                if (w_sel) begin
                    w_val_next = (w_val_next & ~Rw) | (wdata_i & Rw);
                end
                if (hw_we_i[gi]) begin
                    w_val_next = (w_val_next & ~Hw) | (hw_data_i[gi*DataWidth +: DataWidth] & Hw);
                end
                // Hardware set is applied last so it wins over a same-cycle software clear.
                w_val_next = (w_val_next & ~(W1c & {DataWidth{w_sel}} & wdata_i))
                           | (W1c & hw_set_i[gi*DataWidth +: DataWidth]);
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_val         <= RstVal;
                    r_wr_pulse[gi] <= 1'b0;
                end else begin
                    r_val         <= w_val_next;
                    r_wr_pulse[gi] <= w_sel;
                end
            end

            assign w_regs[gi*DataWidth +: DataWidth] = r_val;
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        for (int r = 0; r < NumRegs; r++) begin
            if (w_addr_ext == r[31:0]) begin
                w_rd_data = w_regs[r*DataWidth +: DataWidth];
            end
        end
    end

    // Readback samples the pre-update register contents (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (re_i) begin
                r_rdata <= w_in_range ? w_rd_data : '0;
            end
            r_rvalid <= re_i;
            r_err    <= (re_i || we_i) && !w_in_range;
            r_irq    <= |(w_regs[IrqStatReg*DataWidth +: DataWidth]
                        & w_regs[IrqEnReg*DataWidth +: DataWidth] & IrqMask);
        end
    end

    assign rdata_o    = r_rdata;
    assign rvalid_o   = r_rvalid;
    assign err_o      = r_err;
    assign wr_pulse_o = r_wr_pulse;
    assign irq_o      = r_irq;
    assign regs_o     = w_regs;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: reset, bit classes, W1C/irq, read-before-write,
// out-of-range handling and streaming reads.
module tb_reg_bank;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 5;

    localparam logic [NR*DW-1:0] RST_V  = (256'h0123 << (1*DW)) | (256'h0011 << (5*DW));
    localparam logic [NR*DW-1:0] SW_M   = (256'hFFFF << (3*DW)) | (256'hFF00 << (5*DW))
                                        | (256'hFFFF << (10*DW));
    localparam logic [NR*DW-1:0] W1C_M  = (256'h1000 << (9*DW));

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     addr_i;
    logic [DW-1:0]     wdata_i;
    logic              we_i;
    logic              re_i;
    logic [DW-1:0]     rdata_o;
    logic              rvalid_o;
    logic              err_o;
    logic [NR*DW-1:0]  hw_data_i;
    logic [NR-1:0]     hw_we_i;
    logic [NR*DW-1:0]  hw_set_i;
    logic [NR*DW-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;
    logic              irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_regs [NR];

    reg_bank #(
        .DataWidth(DW), .NumRegs(NR), .AddrWidth(AW),
        .ResetValue(RST_V), .SwWrMask(SW_M), .W1cMask(W1C_M),
        .IrqStatReg(9), .IrqEnReg(10)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .err_o(err_o), .hw_data_i(hw_data_i), .hw_we_i(hw_we_i),
        .hw_set_i(hw_set_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_regs(input string tag);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s_reg%0d", tag, r), 32'(regs_o[r*DW +: DW]), 32'(exp_regs[r]));
        end
    endtask

    task automatic idle();
        we_i = 1'b0; re_i = 1'b0; hw_we_i = '0; hw_set_i = '0;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) exp_regs[r] = '0;
        exp_regs[1] = 16'h0123;
        exp_regs[5] = 16'h0011;

        // Reset with an access presented: it must be discarded.
        rst_i = 1'b1; addr_i = 5'd3; wdata_i = 16'hFFFF; we_i = 1'b1; re_i = 1'b1;
        hw_data_i = '0; hw_we_i = '0; hw_set_i = '0;
        tick();
        tick();
        chk_all_regs("reset");
        chk("reset_rvalid", 32'(rvalid_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_rdata", 32'(rdata_o), 32'd0);
        chk("reset_wr_pulse", 32'(wr_pulse_o), 32'd0);
        chk("reset_irq", 32'(irq_o), 32'd0);
        rst_i = 1'b0; idle();
        tick();
        chk("post_reset_wr_pulse", 32'(wr_pulse_o), 32'd0);
        chk("post_reset_reg3", 32'(regs_o[3*DW +: DW]), 32'h0000);

        // RW/HW mix on reg5.
        we_i = 1'b1; addr_i = 5'd5; wdata_i = 16'hABCD;
        tick();
        idle();
        chk("rwhw_sw_reg5", 32'(regs_o[5*DW +: DW]), 32'hAB11);
        chk("rwhw_sw_pulse", 32'(wr_pulse_o), 32'h0020);
        hw_we_i[5] = 1'b1; hw_data_i[5*DW +: DW] = 16'hFF55;
        tick();
        idle();
        chk("rwhw_hw_reg5", 32'(regs_o[5*DW +: DW]), 32'hAB55);
        chk("rwhw_hw_pulse", 32'(wr_pulse_o), 32'h0000);
        exp_regs[5] = 16'hAB55;

        // Software write to a hardware-owned register: data ignored, pulse still fires.
        we_i = 1'b1; addr_i = 5'd1; wdata_i = 16'hFFFF;
        tick();
        idle();
        chk("hwonly_reg1", 32'(regs_o[1*DW +: DW]), 32'h0123);
        chk("hwonly_pulse", 32'(wr_pulse_o), 32'h0002);

        // Enable irq bit 12 in reg10, then sticky set / collision / clear on reg9.
        we_i = 1'b1; addr_i = 5'd10; wdata_i = 16'h1000;
        tick();
        idle();
        exp_regs[10] = 16'h1000;
        hw_set_i[9*DW + 12] = 1'b1;
        tick();
        idle();
        chk("w1c_set_reg9", 32'(regs_o[9*DW +: DW]), 32'h1000);
        chk("w1c_irq_n1", 32'(irq_o), 32'd0);
        tick();
        chk("w1c_irq_n2", 32'(irq_o), 32'd1);
        hw_set_i[9*DW + 12] = 1'b1; we_i = 1'b1; addr_i = 5'd9; wdata_i = 16'h1000;
        tick();
        idle();
        chk("w1c_collide_reg9", 32'(regs_o[9*DW +: DW]), 32'h1000);
        chk("w1c_collide_pulse", 32'(wr_pulse_o), 32'h0200);
        we_i = 1'b1; addr_i = 5'd9; wdata_i = 16'h1000;
        tick();
        idle();
        chk("w1c_clear_reg9", 32'(regs_o[9*DW +: DW]), 32'h0000);
        chk("w1c_clear_irq_n1", 32'(irq_o), 32'd1);
        tick();
        chk("w1c_clear_irq_n2", 32'(irq_o), 32'd0);

        // Read-before-write on reg3.
        we_i = 1'b1; re_i = 1'b1; addr_i = 5'd3; wdata_i = 16'h1234;
        tick();
        we_i = 1'b0;
        chk("rbw_rdata_old", 32'(rdata_o), 32'h0000);
        chk("rbw_rvalid", 32'(rvalid_o), 32'd1);
        chk("rbw_reg3", 32'(regs_o[3*DW +: DW]), 32'h1234);
        tick();
        idle();
        exp_regs[3] = 16'h1234;
        chk("rbw_rdata_new", 32'(rdata_o), 32'h1234);
        tick();
        chk("rbw_rvalid_low", 32'(rvalid_o), 32'd0);
        chk("rbw_rdata_hold", 32'(rdata_o), 32'h1234);

        // Out-of-range write then read.
        we_i = 1'b1; addr_i = 5'd20; wdata_i = 16'hFFFF;
        tick();
        idle();
        chk("oor_wr_err", 32'(err_o), 32'd1);
        chk("oor_wr_pulse", 32'(wr_pulse_o), 32'h0000);
        chk("oor_wr_rvalid", 32'(rvalid_o), 32'd0);
        chk_all_regs("oor_wr");
        re_i = 1'b1; addr_i = 5'd20;
        tick();
        idle();
        chk("oor_rd_rdata", 32'(rdata_o), 32'h0000);
        chk("oor_rd_rvalid", 32'(rvalid_o), 32'd1);
        chk("oor_rd_err", 32'(err_o), 32'd1);
        tick();
        chk("oor_err_clear", 32'(err_o), 32'd0);

        // Streaming reads of every register on consecutive cycles.
        for (int i = 0; i < NR; i++) begin
            re_i = 1'b1; addr_i = AW'(i);
            tick();
            chk($sformatf("stream_rvalid%0d", i), 32'(rvalid_o), 32'd1);
            chk($sformatf("stream_rdata%0d", i), 32'(rdata_o), 32'(exp_regs[i]));
        end
        idle();
        tick();
        chk("stream_end_rvalid", 32'(rvalid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
